// File: rtl/taxi_eth_mac_stat_cnt.sv
// Multi-port MAC statistics accumulator: live counters per port, a snapshot
// shadow bank with optional clear, and a one-cycle-latency shadow read port.
module taxi_eth_mac_stat_cnt #(
  parameter int PORTS  = 1,
  parameter int CNT_W  = 32,
  parameter int INC_W  = 4,
  parameter int SAT_EN = 1,
  localparam int ADDR_W = $clog2(PORTS) + 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS*12-1:0]      stat_evt,
  input  logic [PORTS*INC_W-1:0]   stat_rx_byte,
  input  logic [PORTS*INC_W-1:0]   stat_tx_byte,
  input  logic                     snap,
  input  logic                     snap_clr,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_valid,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     rd_err,
  output logic [PORTS-1:0]         ovf
);

  localparam int NCNT   = PORTS * 14;
  localparam int FLAT_W = $clog2(NCNT);

  logic [NCNT-1:0][CNT_W-1:0] live_q;
  logic [NCNT-1:0][CNT_W-1:0] shadow_q;
  logic [NCNT-1:0][CNT_W-1:0] cnt_next;
  logic [NCNT-1:0]            cnt_carry;
  logic [PORTS-1:0]           port_carry;

  // Flat counter k = port*14 + idx; idx 0..11 are event bits, 12 rx bytes, 13 tx bytes.
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    for (genvar c = 0; c < 14; c++) begin : g_cnt
      logic [CNT_W:0] inc;
      logic [CNT_W:0] sum;
      if (c < 12) begin : g_evt
        assign inc = {{CNT_W{1'b0}}, stat_evt[p*12+c]};
      end else if (c == 12) begin : g_rx
        assign inc = {{(CNT_W+1-INC_W){1'b0}}, stat_rx_byte[p*INC_W +: INC_W]};
      end else begin : g_tx
        assign inc = {{(CNT_W+1-INC_W){1'b0}}, stat_tx_byte[p*INC_W +: INC_W]};
      end
      assign sum = {1'b0, live_q[p*14+c]} + inc;
      assign cnt_carry[p*14+c] = sum[CNT_W];
      assign cnt_next[p*14+c]  = (sum[CNT_W] && SAT_EN != 0) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
    assign port_carry[p] = |cnt_carry[p*14 +: 14];
  end

  // Shadow captures the post-update value, so a clearing snapshot loses nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q   <= '0;
      shadow_q <= '0;
      ovf      <= '0;
    end else begin
      if (snap) begin
        shadow_q <= cnt_next;
      end
      if (snap && snap_clr) begin
        live_q <= '0;
        ovf    <= '0;
      end else begin
        live_q <= cnt_next;
        ovf    <= ovf | port_carry;
      end
    end
  end

  logic [ADDR_W-1:0] rd_port;
  logic [3:0]        rd_idx;
  logic              rd_ok;
  logic [FLAT_W-1:0] rd_flat;
  logic [CNT_W-1:0]  rd_sel;

  assign rd_port = rd_addr >> 4;
  assign rd_idx  = rd_addr[3:0];

  always_comb begin
    rd_ok   = (32'(rd_port) < PORTS) && (rd_idx < 4'd14);
    rd_flat = '0;
    rd_sel  = '0;
    if (rd_ok) begin
      rd_flat = FLAT_W'(32'(rd_port) * 14 + 32'(rd_idx));
      rd_sel  = shadow_q[rd_flat];
    end
  end

  // Read sees shadow_q before any same-cycle snapshot lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_sel;
        rd_err  <= ~rd_ok;
      end
    end
  end

endmodule

// File: tb/tb_taxi_eth_mac_stat_cnt.sv
// Bench for taxi_eth_mac_stat_cnt: a saturating and a wrapping instance share
// stimulus and are checked against an arithmetic model every cycle.
module tb_taxi_eth_mac_stat_cnt;

  localparam int PORTS  = 3;
  localparam int CNT_W  = 16;
  localparam int INC_W  = 4;
  localparam int ADDR_W = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PORTS*12-1:0]    stat_evt;
  logic [PORTS*INC_W-1:0] stat_rx_byte;
  logic [PORTS*INC_W-1:0] stat_tx_byte;
  logic                   snap;
  logic                   snap_clr;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;

  logic             s_rd_valid, w_rd_valid;
  logic [CNT_W-1:0] s_rd_data, w_rd_data;
  logic             s_rd_err, w_rd_err;
  logic [PORTS-1:0] s_ovf, w_ovf;

  taxi_eth_mac_stat_cnt #(.PORTS(PORTS), .CNT_W(CNT_W), .INC_W(INC_W), .SAT_EN(1)) dut_sat (
    .clk(clk), .rst(rst), .stat_evt(stat_evt), .stat_rx_byte(stat_rx_byte),
    .stat_tx_byte(stat_tx_byte), .snap(snap), .snap_clr(snap_clr), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_err(s_rd_err),
    .ovf(s_ovf)
  );

  taxi_eth_mac_stat_cnt #(.PORTS(PORTS), .CNT_W(CNT_W), .INC_W(INC_W), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .stat_evt(stat_evt), .stat_rx_byte(stat_rx_byte),
    .stat_tx_byte(stat_tx_byte), .snap(snap), .snap_clr(snap_clr), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(w_rd_valid), .rd_data(w_rd_data), .rd_err(w_rd_err),
    .ovf(w_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Instance 0 saturates, instance 1 wraps; values held as plain integers.
  longint      live_m[2][PORTS][14];
  longint      shad_m[2][PORTS][14];
  bit          ovf_m[2][PORTS];
  bit          m_valid;
  logic [16:0] exp_q_s[$];
  logic [16:0] exp_q_w[$];
  int          m_port, m_idx;
  longint      m_inc, m_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < PORTS; p++) begin
          ovf_m[k][p] = 1'b0;
          for (int c = 0; c < 14; c++) begin
            live_m[k][p][c] = 0;
            shad_m[k][p][c] = 0;
          end
        end
      m_valid = 1'b0;
      exp_q_s.delete();
      exp_q_w.delete();
    end else begin
      m_valid = rd_en;
      if (rd_en) begin
        m_port = int'(rd_addr[5:4]);
        m_idx  = int'(rd_addr[3:0]);
        if (m_port < PORTS && m_idx < 14) begin
          exp_q_s.push_back({1'b0, 16'(shad_m[0][m_port][m_idx])});
          exp_q_w.push_back({1'b0, 16'(shad_m[1][m_port][m_idx])});
        end else begin
          exp_q_s.push_back({1'b1, 16'h0000});
          exp_q_w.push_back({1'b1, 16'h0000});
        end
      end
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < PORTS; p++)
          for (int c = 0; c < 14; c++) begin
            if (c < 12)       m_inc = longint'(stat_evt[p*12+c]);
            else if (c == 12) m_inc = longint'(stat_rx_byte[p*4 +: 4]);
            else              m_inc = longint'(stat_tx_byte[p*4 +: 4]);
            m_v = live_m[k][p][c] + m_inc;
            if (m_v > 65535) begin
              ovf_m[k][p] = 1'b1;
              m_v = (k == 0) ? 65535 : m_v - 65536;
            end
            live_m[k][p][c] = m_v;
          end
      if (snap) begin
        shad_m = live_m;
        if (snap_clr) begin
          for (int k = 0; k < 2; k++)
            for (int p = 0; p < PORTS; p++) begin
              ovf_m[k][p] = 1'b0;
              for (int c = 0; c < 14; c++) live_m[k][p][c] = 0;
            end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [16:0]      sb_e;
  logic [PORTS-1:0] sb_ovf_s, sb_ovf_w;

  always @(negedge clk) begin
    chk("rd_valid_sat", 64'(s_rd_valid), 64'(m_valid));
    chk("rd_valid_wrap", 64'(w_rd_valid), 64'(m_valid));
    if (m_valid) begin
      if (exp_q_s.size() == 0 || exp_q_w.size() == 0) begin
        chk("sb_queue_empty", 64'(1), 64'(0));
      end else begin
        sb_e = exp_q_s.pop_front();
        chk("sb_rd_sat", 64'({s_rd_err, s_rd_data}), 64'(sb_e));
        sb_e = exp_q_w.pop_front();
        chk("sb_rd_wrap", 64'({w_rd_err, w_rd_data}), 64'(sb_e));
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      sb_ovf_s[p] = ovf_m[0][p];
      sb_ovf_w[p] = ovf_m[1][p];
    end
    chk("sb_ovf_sat", 64'(s_ovf), 64'(sb_ovf_s));
    chk("sb_ovf_wrap", 64'(w_ovf), 64'(sb_ovf_w));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic read_chk(input logic [5:0] a, input logic [15:0] es, input logic [15:0] ew,
                          input logic eerr, input string nm);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({nm, "_valid"}, 64'(s_rd_valid & w_rd_valid), 64'(1));
    chk({nm, "_sat"}, 64'(s_rd_data), 64'(es));
    chk({nm, "_wrap"}, 64'(w_rd_data), 64'(ew));
    chk({nm, "_err"}, 64'({s_rd_err, w_rd_err}), 64'({eerr, eerr}));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 64'({s_rd_valid, w_rd_valid}), 64'(0));
    chk({nm, "_data"}, 64'({s_rd_data, w_rd_data}), 64'(0));
    chk({nm, "_err"}, 64'({s_rd_err, w_rd_err}), 64'(0));
    chk({nm, "_ovf"}, 64'({s_ovf, w_ovf}), 64'(0));
  endtask

  logic [63:0] rnd;

  initial begin
    stat_evt = '0; stat_rx_byte = '0; stat_tx_byte = '0;
    snap = 1'b0; snap_clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst = 1'b0;

    // Every valid address reads zero after reset.
    for (int p = 0; p < PORTS; p++)
      for (int i = 0; i < 14; i++)
        read_chk(6'((p << 4) | i), 16'h0, 16'h0, 1'b0, "rd_reset_zero");

    // Port 1: five tx_pkt_good pulses, ten cycles of 8 tx bytes.
    for (int i = 0; i < 10; i++) begin
      stat_evt[19]      = (i < 5);
      stat_tx_byte[7:4] = 4'd8;
      tick();
    end
    stat_evt = '0; stat_tx_byte = '0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    read_chk(6'h17, 16'd5, 16'd5, 1'b0, "rd_p1_txgood");
    read_chk(6'h1D, 16'd80, 16'd80, 1'b0, "rd_p1_txbyte");
    read_chk(6'h07, 16'd0, 16'd0, 1'b0, "rd_p0_txgood");
    read_chk(6'h0D, 16'd0, 16'd0, 1'b0, "rd_p0_txbyte");
    read_chk(6'h30, 16'd0, 16'd0, 1'b1, "rd_bad_port");
    read_chk(6'h1D, 16'd80, 16'd80, 1'b0, "rd_p1_txbyte_again");
    read_chk(6'h0E, 16'd0, 16'd0, 1'b1, "rd_bad_idx14");
    read_chk(6'h1D, 16'd80, 16'd80, 1'b0, "rd_p1_txbyte_again2");
    read_chk(6'h1F, 16'd0, 16'd0, 1'b1, "rd_bad_idx15");

    // Read in the snapshot cycle returns the old shadow, next cycle the new one.
    stat_evt[19] = 1'b1; snap = 1'b1; rd_en = 1'b1; rd_addr = 6'h17;
    tick();
    stat_evt = '0; snap = 1'b0; rd_en = 1'b0;
    chk("rd_snap_same_cycle", 64'({s_rd_data, w_rd_data}), 64'({16'd5, 16'd5}));
    read_chk(6'h17, 16'd6, 16'd6, 1'b0, "rd_snap_next_cycle");

    // Event coincident with a clearing snapshot lands in the shadow only.
    stat_evt[0] = 1'b1; snap = 1'b1; snap_clr = 1'b1;
    tick();
    stat_evt = '0; snap = 1'b0; snap_clr = 1'b0;
    read_chk(6'h00, 16'd1, 16'd1, 1'b0, "rd_clr_evt_in_shadow");
    read_chk(6'h17, 16'd6, 16'd6, 1'b0, "rd_clr_txgood");
    read_chk(6'h1D, 16'd80, 16'd80, 1'b0, "rd_clr_txbyte");
    snap = 1'b1;
    tick();
    snap = 1'b0;
    read_chk(6'h00, 16'd0, 16'd0, 1'b0, "rd_after_clr_evt");
    read_chk(6'h17, 16'd0, 16'd0, 1'b0, "rd_after_clr_txgood");
    read_chk(6'h1D, 16'd0, 16'd0, 1'b0, "rd_after_clr_txbyte");

    // Port 2 byte counters to 0xFFFE, then overflow.
    stat_rx_byte[11:8] = 4'd15; stat_tx_byte[11:8] = 4'd15;
    repeat (4368) tick();
    stat_rx_byte[11:8] = 4'd14; stat_tx_byte[11:8] = 4'd14;
    tick();
    chk("ovf_before_wrap", 64'({s_ovf, w_ovf}), 64'(0));
    stat_rx_byte[11:8] = 4'd5; stat_tx_byte[11:8] = 4'd0;
    tick();
    chk("ovf_sat_set", 64'(s_ovf), 64'(3'b100));
    chk("ovf_wrap_set", 64'(w_ovf), 64'(3'b100));
    tick();
    chk("ovf_held", 64'({s_ovf, w_ovf}), 64'({3'b100, 3'b100}));
    stat_rx_byte[11:8] = 4'd0; stat_tx_byte[11:8] = 4'd5;
    snap = 1'b1; snap_clr = 1'b1;
    tick();
    stat_tx_byte = '0; snap = 1'b0; snap_clr = 1'b0;
    chk("ovf_clear_wins", 64'({s_ovf, w_ovf}), 64'(0));
    read_chk(6'h2C, 16'hFFFF, 16'h0008, 1'b0, "rd_p2_rxbyte_ovf");
    read_chk(6'h2D, 16'hFFFF, 16'h0003, 1'b0, "rd_p2_txbyte_ovf");

    // Asynchronous reset in the middle of accumulation with a read in flight.
    stat_rx_byte[11:8] = 4'd15; rd_en = 1'b1; rd_addr = 6'h2C;
    tick();
    tick();
    chk("pre_rst_valid", 64'({s_rd_valid, w_rd_valid}), 64'(2'b11));
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    rd_en = 1'b0; stat_rx_byte = '0;
    tick();
    tick();
    rst = 1'b0;
    read_chk(6'h2C, 16'h0, 16'h0, 1'b0, "rd_after_rst");

    // Randomised traffic against the model.
    for (int n = 0; n < 8000; n++) begin
      rnd          = {$urandom, $urandom} & {$urandom, $urandom};
      stat_evt     = rnd[PORTS*12-1:0];
      stat_rx_byte = 12'($urandom);
      stat_tx_byte = 12'($urandom);
      snap         = ($urandom_range(0, 15) == 0);
      snap_clr     = ($urandom_range(0, 63) == 0);
      rd_en        = ($urandom_range(0, 1) == 1);
      rd_addr      = 6'($urandom_range(0, 63));
      tick();
    end
    stat_evt = '0; stat_rx_byte = '0; stat_tx_byte = '0;
    snap = 1'b0; snap_clr = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    chk("sb_queue_drained", 64'(exp_q_s.size() + exp_q_w.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/taxi_eth_mac_stat_cnt.md
# taxi_eth_mac_stat_cnt

Multi-port statistics accumulator for the 10G MAC family. It turns the per-packet status pulses and per-cycle byte counts of up to 8 MAC instances into wide per-port counters. Live counters are copied into a shadow bank on a snapshot command, with optional clear-on-snapshot. Software or a management bridge reads the shadow bank through a one-cycle-latency register read port. The block sits in the stat clock domain beside the MAC instances; the integrator synchronises MAC status pulses into `clk` before they reach this block.

## Interface
- `PORTS`, default 1: number of MAC ports; legal range 1..8.
- `CNT_W`, default 32: counter width; legal range 16..64.
- `INC_W`, default 4: width of each per-cycle byte increment.
- `SAT_EN`, default 1: 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_W.
- `ADDR_W`, derived, = $clog2(PORTS)+4: read address width. Not overridable.

Ports:
- `clk` in, 1: single clock.
- `rst` in, 1: reset, asynchronous and active-high.
- `stat_evt` in, PORTS*12: event pulses; bit p*12+i is event i of port p (indices listed below).
- `stat_rx_byte` in, PORTS*INC_W: RX bytes this cycle; slice p belongs to port p.
- `stat_tx_byte` in, PORTS*INC_W: TX bytes this cycle; slice p belongs to port p.
- `snap` in, 1: copy all live counters to the shadow bank.
- `snap_clr` in, 1: qualifies `snap`; when set, live counters and `ovf` are cleared. Ignored without `snap`.
- `rd_en` in, 1: read request.
- `rd_addr` in, ADDR_W: {port, idx[3:0]}.
- `rd_valid` out, 1: read data valid.
- `rd_data` out, CNT_W: shadow counter value.
- `rd_err` out, 1: addressed port ≥ PORTS, or idx is 14 or 15.
- `ovf` out, PORTS: sticky per-port flag; set when any counter of that port saturates or wraps.

## Operation
- Counter index map (event bit i equals index i for 0..11):
  - 0 rx_pkt_good, 1 rx_pkt_bad, 2 rx_err_bad_fcs, 3 rx_err_preamble, 4 rx_err_framing, 5 rx_err_oversize, 6 rx_pkt_fragment.
  - 7 tx_pkt_good, 8 tx_pkt_bad, 9 tx_err_oversize, 10 tx_err_user, 11 tx_err_underflow.
  - 12 rx_byte, 13 tx_byte.
- Per-port live bank of 14 counters, each CNT_W wide.
  - Event counters add 1 per cycle their bit is high.
  - Byte counters add the zero-extended INC_W increment every cycle.
- Overflow is detected per counter when the sum has a carry out of CNT_W.
  - SAT_EN=1: the counter loads all-ones and holds there until cleared.
  - SAT_EN=0: the counter keeps the low CNT_W bits.
  - Either mode: the port's `ovf` bit is set.
- Snapshot, when `snap` is sampled high:
  - Each shadow register loads the post-update live value, i.e. it includes the increments sampled in the same cycle.
  - With `snap_clr`: every live counter loads 0 and `ovf` clears. Increments of that cycle are therefore in the shadow, never lost and never double-counted.
- Read, when `rd_en` is sampled high:
  - Next cycle: `rd_valid`=1, `rd_data` = the shadow value as it was before any same-cycle snapshot.
  - `rd_err` = 1 for an invalid address, with `rd_data`=0.
  - Otherwise `rd_valid`=0. `rd_data` holds its last value and `rd_err` holds its last value.
- There is no backpressure. A read is accepted every cycle, and back-to-back reads return in issue order.

## Timing
- Reset (async assert, deasserted synchronously by the integrator): all live counters, shadows, `ovf`, `rd_valid`, `rd_data` and `rd_err` are 0.
- Event sampled at edge N is visible in the live counter after edge N. It is visible via read only after a snapshot at edge ≥ N.
- Snapshot takes one cycle. A read issued the cycle after `snap` returns the new shadow.
- Read latency is exactly 1 cycle, from `rd_en` sampled to `rd_valid` high.
- Simultaneous overflow and `snap`+`snap_clr`:
  - The shadow gets the saturated (or wrapped) value.
  - `ovf` reads 0 after the edge, because clear wins.
- Saturated counter with further increments: the value stays all-ones and `ovf` stays set.
- Reset mid-read: `rd_valid` drops immediately (async) and the pending read is discarded.

## Test plan
- Reset, then read every valid address of PORTS=2 → `rd_valid` 1 cycle after each `rd_en`, `rd_data`=0, `rd_err`=0. Address {2,0} and address {0,14} → `rd_err`=1, `rd_data`=0.
- Port 1: pulse stat_evt bit 12+7 for 5 cycles and drive `stat_tx_byte`=8 for 10 cycles; then `snap`; read {1,7} and {1,13} → 5 and 80. Port 0 counters read 0.
- Event on the same cycle as `snap`+`snap_clr`, then a second `snap` → first snapshot includes the event. Second snapshot reads 0 for that counter.
- CNT_W=16, SAT_EN=1: preload to 0xFFFE via 2 pulses short of full, then `stat_rx_byte`=5 → counter reads 0xFFFF and `ovf[0]`=1. With SAT_EN=0 the same stimulus reads 0x0003.
- `rd_en` on the same cycle as `snap` → returns the old shadow. `rd_en` on the next cycle → returns the new shadow.
- Assert `rst` asynchronously mid-accumulation → all outputs are 0 before the next clock edge.
